// File: rtl/bemicro_cv_rst_seq_pkg.sv
// Shared types and constants for the BeMicro CV reset sequencer.
// Optional feature macro: BEMICRO_CV_RST_SEQ_CAL_TIMEOUT_EN (see bemicro_cv_rst_seq.sv).
package bemicro_cv_rst_seq_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_WAIT_CAL  = 3'd3,
    S_SYS_DLY   = 3'd4,
    S_RUN       = 3'd5
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES        = 2;
  localparam int unsigned DEF_PLL_RST_CYCLES     = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 65536;
  localparam int unsigned DEF_CAL_TIMEOUT        = 4194304;
  localparam int unsigned DEF_SYS_DELAY          = 64;

  localparam logic [3:0] RETRY_MAX = 4'd15;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold max_val itself (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((max_val >> i) != 0) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/bemicro_cv_bit_sync.sv
// Multi-stage flip-flop synchronizer for one asynchronous level input.
// Resets asynchronously to 0 so nothing is seen as asserted during board reset.
module bemicro_cv_bit_sync
  import bemicro_cv_rst_seq_pkg::*;
#(
  parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input in at the low end.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/bemicro_cv_rst_seq.sv
// Reset sequencer: PLL reset -> lock stability -> DDR3 reset release -> system reset release.
// Define BEMICRO_CV_RST_SEQ_CAL_TIMEOUT_EN to bound the wait for DDR3 calibration.
module bemicro_cv_rst_seq
  import bemicro_cv_rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int unsigned CAL_TIMEOUT        = DEF_CAL_TIMEOUT,
  parameter int unsigned SYS_DELAY          = DEF_SYS_DELAY
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       cal_done,
  input  logic       cal_fail,
  output logic       pll_rst,
  output logic       mem_rst,
  output logic       sys_rst,
  output logic [2:0] state,
  output logic [3:0] retry_cnt
);

  // A single-flop "synchronizer" is not safe; never build fewer than two stages.
  localparam int unsigned SYNC_EFF  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned MAX_PARAM = max_u(max_u(max_u(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                                  max_u(LOCK_TIMEOUT, CAL_TIMEOUT)),
                                            SYS_DELAY);
  localparam int unsigned CNT_W     = cnt_width(MAX_PARAM);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LD_PLL_RST = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t LD_LOCK_TO = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t LD_STABLE  = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t LD_SYS_DLY = cnt_t'(SYS_DELAY - 1);
`ifdef BEMICRO_CV_RST_SEQ_CAL_TIMEOUT_EN
  localparam cnt_t LD_CAL     = cnt_t'(CAL_TIMEOUT - 1);
`else
  localparam cnt_t LD_CAL     = '0;
`endif

  logic   lock_s;
  logic   cal_done_s;
  logic   cal_fail_s;
  logic   cnt_zero_s;
  cnt_t   cnt_ld_s;

  state_e     state_q,   state_d;
  cnt_t       cnt_q,     cnt_d;
  logic [3:0] retry_q,   retry_d;
  logic       pll_rst_q, pll_rst_d;
  logic       mem_rst_q, mem_rst_d;
  logic       sys_rst_q, sys_rst_d;

  bemicro_cv_bit_sync #(.STAGES(SYNC_EFF)) u_sync_lock (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  bemicro_cv_bit_sync #(.STAGES(SYNC_EFF)) u_sync_cal_done (
    .clk (refclk),
    .rst (rst),
    .d   (cal_done),
    .q   (cal_done_s)
  );

  bemicro_cv_bit_sync #(.STAGES(SYNC_EFF)) u_sync_cal_fail (
    .clk (refclk),
    .rst (rst),
    .d   (cal_fail),
    .q   (cal_fail_s)
  );

  assign cnt_zero_s = (cnt_q == '0);

  // Next-state decision; lock loss outranks cal_fail, which outranks cal_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_zero_s) state_d = S_WAIT_LOCK;
        else            state_d = S_PLL_RST;
      end
      S_WAIT_LOCK: begin
        if (lock_s)          state_d = S_STABLE;
        else if (cnt_zero_s) state_d = S_PLL_RST;
        else                 state_d = S_WAIT_LOCK;
      end
      S_STABLE: begin
        if (!lock_s)         state_d = S_WAIT_LOCK;
        else if (cnt_zero_s) state_d = S_WAIT_CAL;
        else                 state_d = S_STABLE;
      end
      S_WAIT_CAL: begin
        if (!lock_s)         state_d = S_WAIT_LOCK;
        else if (cal_fail_s) state_d = S_PLL_RST;
        else if (cal_done_s) state_d = S_SYS_DLY;
`ifdef BEMICRO_CV_RST_SEQ_CAL_TIMEOUT_EN
        else if (cnt_zero_s) state_d = S_PLL_RST;
`endif
        else                 state_d = S_WAIT_CAL;
      end
      S_SYS_DLY: begin
        if (!lock_s)         state_d = S_WAIT_LOCK;
        else if (cnt_zero_s) state_d = S_RUN;
        else                 state_d = S_SYS_DLY;
      end
      S_RUN: begin
        if (!lock_s) state_d = S_WAIT_LOCK;
        else         state_d = S_RUN;
      end
      default: state_d = S_PLL_RST;
    endcase
  end

  // Counter reload value for the state being entered (cycles minus one).
  always_comb begin
    cnt_ld_s = '0;
    case (state_d)
      S_PLL_RST:   cnt_ld_s = LD_PLL_RST;
      S_WAIT_LOCK: cnt_ld_s = LD_LOCK_TO;
      S_STABLE:    cnt_ld_s = LD_STABLE;
      S_WAIT_CAL:  cnt_ld_s = LD_CAL;
      S_SYS_DLY:   cnt_ld_s = LD_SYS_DLY;
      S_RUN:       cnt_ld_s = '0;
      default:     cnt_ld_s = LD_PLL_RST;
    endcase
  end

  // Counter, retry count and output decode, all taken from the next state.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = cnt_ld_s;
    end else if (!cnt_zero_s) begin
      cnt_d = cnt_q - cnt_t'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end

    if ((state_d == S_PLL_RST) && (state_q != S_PLL_RST) && (retry_q != RETRY_MAX)) begin
      retry_d = retry_q + 4'd1;
    end else begin
      retry_d = retry_q;
    end

    pll_rst_d = (state_d == S_PLL_RST);
    mem_rst_d = !((state_d == S_WAIT_CAL) || (state_d == S_SYS_DLY) || (state_d == S_RUN));
    // sys_rst only drops in S_RUN, where mem_rst is already low.
    sys_rst_d = (state_d != S_RUN);
  end

  // Sequencer state and registered Moore outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= LD_PLL_RST;
      retry_q   <= 4'd0;
      pll_rst_q <= 1'b1;
      mem_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      mem_rst_q <= mem_rst_d;
      sys_rst_q <= sys_rst_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign mem_rst   = mem_rst_q;
  assign sys_rst   = sys_rst_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_bemicro_cv_rst_seq.sv
// Scoreboard bench for bemicro_cv_rst_seq: an elapsed-time phase model predicts output
// changes, a negedge monitor pops and compares them. Honours BEMICRO_CV_RST_SEQ_CAL_TIMEOUT_EN.
module tb_bemicro_cv_rst_seq;

  localparam int SS = 2, PRC = 4, LSC = 8, LTO = 32, CTO = 64, SDL = 5;
  localparam int ST_PLL = 0, ST_WL = 1, ST_STB = 2, ST_WC = 3, ST_SD = 4, ST_RUN = 5;
  localparam logic [9:0] RST_T = 10'b111_000_0000;
`ifdef BEMICRO_CV_RST_SEQ_CAL_TIMEOUT_EN
  localparam bit CAL_TO_EN = 1'b1;
`else
  localparam bit CAL_TO_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, pll_locked = 1'b0, cal_done = 1'b0, cal_fail = 1'b0;
  logic pll_rst, mem_rst, sys_rst;
  logic [2:0] state;
  logic [3:0] retry_cnt;

  bemicro_cv_rst_seq #(
    .SYNC_STAGES(SS), .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC),
    .LOCK_TIMEOUT(LTO), .CAL_TIMEOUT(CTO), .SYS_DELAY(SDL)
  ) dut (
    .refclk(clk), .rst(rst), .pll_locked(pll_locked), .cal_done(cal_done),
    .cal_fail(cal_fail), .pll_rst(pll_rst), .mem_rst(mem_rst), .sys_rst(sys_rst),
    .state(state), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [9:0]  val;
  } ev_t;

  ev_t  sb[$];
  ev_t  mon_e;
  int   checks = 0, errors = 0, rel_cyc = 0;
  logic lock_v [0:1023];
  logic done_v [0:1023];
  logic fail_v [0:1023];
  int   m_st, m_entry, m_retry;
  logic [9:0] m_last, mon_last = RST_T, mon_cur;
  logic mon_rst_chk = 1'b0;
  int   r_lock, r_cal, r_done, r_drop, r_ret;
  logic rnd_lk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, rel_cyc);
    end
  endtask

  // What the FSM sees at edge t: the pin value from SS+1 edges back, 0 until the syncs fill.
  function automatic logic [2:0] seen3(input int t);
    if (t < SS + 1) return 3'b000;
    return {lock_v[t-SS-1], done_v[t-SS-1], fail_v[t-SS-1]};
  endfunction

  function automatic logic [9:0] pack_exp(input int st, input int rt);
    logic p, m, s;
    p = (st == ST_PLL);
    m = !(st == ST_WC || st == ST_SD || st == ST_RUN);
    s = (st != ST_RUN);
    return {p, m, s, 3'(st), 4'(rt)};
  endfunction

  task automatic model_reset();
    m_st = ST_PLL; m_entry = 0; m_retry = 0; m_last = RST_T;
    sb.delete();
  endtask

  // Phase model: each phase remembers the edge it was entered and compares elapsed time.
  task automatic model_step(input int t);
    logic [2:0] in;
    int el, nx;
    logic [9:0] cur;
    in = seen3(t);
    el = t - m_entry;
    nx = m_st;
    case (m_st)
      ST_PLL: if (el >= PRC) nx = ST_WL;
      ST_WL:  if (in[2]) nx = ST_STB; else if (el >= LTO) nx = ST_PLL;
      ST_STB: if (!in[2]) nx = ST_WL; else if (el >= LSC) nx = ST_WC;
      ST_WC: begin
        if (!in[2]) nx = ST_WL;
        else if (in[0]) nx = ST_PLL;
        else if (in[1]) nx = ST_SD;
        else if (CAL_TO_EN && el >= CTO) nx = ST_PLL;
      end
      ST_SD:  if (!in[2]) nx = ST_WL; else if (el >= SDL) nx = ST_RUN;
      ST_RUN: if (!in[2]) nx = ST_WL;
      default: nx = ST_PLL;
    endcase
    if (nx != m_st) begin
      if (nx == ST_PLL && m_retry < 15) m_retry++;
      m_st = nx;
      m_entry = t;
    end
    cur = pack_exp(m_st, m_retry);
    if (cur != m_last) begin
      sb.push_back('{cyc: 32'(t), val: cur});
      m_last = cur;
    end
  endtask

  task automatic drive_k(input int id, input int k);
    logic lk, dn, fl;
    lk = 1'b0; dn = 1'b0; fl = 1'b0;
    case (id)
      0, 5: begin lk = (k >= 10); dn = (k >= 40); end
      1: lk = (k >= r_lock && k < r_lock + 5) || (k >= r_lock + 6);
      2: lk = 1'b0;
      3: begin lk = (k >= r_lock); dn = (k == r_cal); fl = (k == r_cal); end
      4: begin lk = (k >= r_lock && k < r_drop) || (k >= r_ret); dn = (k >= r_done); end
      6: begin
        if ($urandom_range(0, 39) == 0) rnd_lk = !rnd_lk;
        lk = rnd_lk;
        dn = ($urandom_range(0, 19) == 0);
        fl = ($urandom_range(0, 59) == 0);
      end
      7: lk = (k >= r_lock);
      default: lk = 1'b0;
    endcase
    lock_v[k] = lk; done_v[k] = dn; fail_v[k] = fl;
    pll_locked = lk; cal_done = dn; cal_fail = fl;
  endtask

  // Monitor: reset value check while in reset, otherwise every output change pops one event.
  always @(negedge clk) begin
    mon_cur = {pll_rst, mem_rst, sys_rst, state, retry_cnt};
    if (rst) begin
      if (!mon_rst_chk) begin
        checks++;
        if (mon_cur != RST_T) begin
          errors++;
          $display("FAIL reset_value: got %b expected %b", mon_cur, RST_T);
        end
        mon_rst_chk = 1'b1;
      end
      mon_last = RST_T;
    end else begin
      mon_rst_chk = 1'b0;
      if (mon_cur != mon_last) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %b at cycle %0d, no change expected", mon_cur, rel_cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.val != mon_cur || mon_e.cyc != 32'(rel_cyc)) begin
            errors++;
            $display("FAIL event: got %b at cycle %0d expected %b at cycle %0d",
                     mon_cur, rel_cyc, mon_e.val, mon_e.cyc);
          end
        end
        mon_last = mon_cur;
      end
    end
  end

  task automatic run_scn(input int id, input int n, input int probe_at);
    rst = 1'b1;
    pll_locked = 1'b0; cal_done = 1'b0; cal_fail = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    rel_cyc = 0;
    drive_k(id, 0);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      rel_cyc = k;
      model_step(k);
      if (k == probe_at) begin
        chk("lockloss_state", int'(state), ST_WL);
        chk("lockloss_mem_rst", int'(mem_rst), 1);
        chk("lockloss_sys_rst", int'(sys_rst), 1);
      end
      drive_k(id, k);
    end
    @(negedge clk);
    #1;
    chk("events_pending", sb.size(), 0);
    chk("final_state", int'(state), m_st);
    chk("final_retry", int'(retry_cnt), m_retry);
  endtask

  initial begin
    // Nominal bring-up: pll_rst@4, mem_rst@21, sys_rst@48.
    run_scn(0, 60, -1);
    chk("nominal_state", int'(state), 5);
    chk("nominal_retry", int'(retry_cnt), 0);
    chk("nominal_sys_rst", int'(sys_rst), 0);

    r_lock = $urandom_range(2, 15);
    run_scn(1, r_lock + 40, -1);
    chk("glitch_state", int'(state), ST_WC);
    chk("glitch_mem_rst", int'(mem_rst), 0);

    run_scn(2, 15 * (LTO + PRC) + 40, -1);
    chk("timeout_retry_sat", int'(retry_cnt), 15);

    r_lock = $urandom_range(3, 10);
    r_cal  = r_lock + 11 + $urandom_range(0, 9);
    run_scn(3, r_cal + SS + 1, -1);
    chk("calfail_state", int'(state), 0);
    chk("calfail_retry", int'(retry_cnt), 1);
    chk("calfail_mem_rst", int'(mem_rst), 1);

    r_lock = $urandom_range(3, 10);
    r_done = r_lock + 12 + $urandom_range(0, 10);
    r_drop = r_done + 10 + $urandom_range(0, 10);
    r_ret  = r_drop + 1 + $urandom_range(0, 8);
    run_scn(4, r_ret + 30, r_drop + SS + 1);
    chk("relock_state", int'(state), 5);

    // Stop in S_SYS_DLY (entered at 43) and pull rst between clock edges.
    run_scn(5, 45, -1);
    chk("sysdly_state", int'(state), ST_SD);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", int'({pll_rst, mem_rst, sys_rst, state, retry_cnt}), int'(RST_T));

    rnd_lk = 1'b1;
    run_scn(6, 400, -1);

    r_lock = $urandom_range(3, 10);
    run_scn(7, r_lock + 11 + CTO + 5, -1);
    chk("caltimeout_state", int'(state), CAL_TO_EN ? 0 : 3);
    chk("caltimeout_retry", int'(retry_cnt), CAL_TO_EN ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
